// File: rtl/lc3_imm_encoder_if.sv
// Input and output streaming channels of the LC-3 immediate encoder, grouped as one bus.
// The master drives words in and accepts results; the slave is the encoder itself.
interface lc3_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [3:0]  in_width;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [10:0] out_field;
  logic        out_ovf;

  modport master (
    output in_valid, in_value, in_width, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_field, out_ovf
  );

  modport slave (
    input  in_valid, in_value, in_width, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_field, out_ovf
  );
endinterface

// File: rtl/lc3_imm_encoder.sv
// Narrows a 16-bit signed value into an LC-3 imm/offset field and packs it into an instruction, 1-cycle latency.
// Output FIFO of DEPTH entries; in_ready is registered from occupancy only. LC3_IMM_SAT_EN clamps overflowing fields.
module lc3_imm_encoder #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  lc3_imm_encoder_if.slave bus,
  output logic [ERR_W-1:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] ONE_C   = 1;

  typedef struct packed {
    logic [15:0] instr;
    logic [10:0] field;
    logic        ovf;
  } entry_t;

  entry_t             enc;
  logic               legal;
  logic               fit;
  logic [10:0]        mask;
  logic [10:0]        field_max;
  logic [10:0]        field_min;
  logic signed [15:0] upper;

  // Value fits W bits when bits [15:W-1] are a pure sign extension, i.e. the
  // arithmetic shift by W-1 leaves all zeros or all ones.
  always_comb begin
    legal     = (bus.in_width == 4'd5) || (bus.in_width == 4'd6) ||
                (bus.in_width == 4'd9) || (bus.in_width == 4'd11);
    mask      = legal ? (11'h7FF >> (4'd11 - bus.in_width)) : 11'h000;
    field_max = mask >> 1;
    field_min = mask & ~field_max;
    upper     = $signed(bus.in_value) >>> (bus.in_width - 4'd1);
    fit       = (upper == 16'sd0) || (&upper);

    enc.instr = bus.in_instr;
    enc.field = 11'h000;
    enc.ovf   = 1'b1;
    if (legal) begin
      enc.ovf   = ~fit;
      enc.field = bus.in_value[10:0] & mask;
`ifdef LC3_IMM_SAT_EN
      if (!fit) enc.field = bus.in_value[15] ? field_min : field_max;
`endif
      enc.instr = (bus.in_instr & ~{5'b00000, mask}) | {5'b00000, enc.field};
    end
  end

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_nxt;
  logic               in_ready_q;
  logic               push;
  logic               pop;
  entry_t             head;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + ONE_C;
    else if (pop && !push) count_nxt = count - ONE_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
      err_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      in_ready_q <= (count_nxt < DEPTH_C);
      if (push && enc.ovf && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until count says an entry is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  assign head          = mem[rd_ptr];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? head.instr : 16'h0000;
  assign bus.out_field = bus.out_valid ? head.field : 11'h000;
  assign bus.out_ovf   = bus.out_valid ? head.ovf   : 1'b0;

endmodule

// File: tb/tb_lc3_imm_encoder.sv
// Directed bench for lc3_imm_encoder: encode vectors, backpressure, reset flush, error saturation.
module tb_lc3_imm_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_count;
  int         n_cmp = 0;
  int         n_err = 0;

  lc3_imm_encoder_if bus_if ();

  lc3_imm_encoder #(.DEPTH(2), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] w, input logic [15:0] ins);
    bus_if.in_valid = 1'b1;
    bus_if.in_value = v;
    bus_if.in_width = w;
    bus_if.in_instr = ins;
  endtask

  // Single word through an empty FIFO with out_ready=1: visible one cycle after accept, gone the next.
  task automatic send_chk(input string tag, input logic [15:0] v, input logic [3:0] w,
                          input logic [15:0] ins, input logic [15:0] e_instr,
                          input logic [10:0] e_field, input logic e_ovf, input logic [7:0] e_err);
    chk({tag, ".rdy"}, 32'(bus_if.in_ready), 32'd1);
    chk({tag, ".pre_vld"}, 32'(bus_if.out_valid), 32'd0);
    drive(v, w, ins);
    tick();
    bus_if.in_valid = 1'b0;
    chk({tag, ".vld"}, 32'(bus_if.out_valid), 32'd1);
    chk({tag, ".instr"}, 32'(bus_if.out_instr), 32'(e_instr));
    chk({tag, ".field"}, 32'(bus_if.out_field), 32'(e_field));
    chk({tag, ".ovf"}, 32'(bus_if.out_ovf), 32'(e_ovf));
    chk({tag, ".err"}, 32'(err_count), 32'(e_err));
    tick();
    chk({tag, ".drain"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_value  = 16'h0000;
    bus_if.in_width  = 4'd0;
    bus_if.in_instr  = 16'h0000;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst.out_instr", 32'(bus_if.out_instr), 32'd0);
    chk("rst.out_field", 32'(bus_if.out_field), 32'd0);
    chk("rst.out_ovf", 32'(bus_if.out_ovf), 32'd0);
    chk("rst.err", 32'(err_count), 32'd0);
    chk("rst.in_ready", 32'(bus_if.in_ready), 32'd1);

    bus_if.out_ready = 1'b1;
    send_chk("t1_neg16", 16'hFFF0, 4'd5, 16'h1020, 16'h1030, 11'h010, 1'b0, 8'd0);
    send_chk("t1_pos15", 16'h000F, 4'd5, 16'h1020, 16'h102F, 11'h00F, 1'b0, 8'd0);
    send_chk("t1_w6min", 16'hFFE0, 4'd6, 16'h0000, 16'h0020, 11'h020, 1'b0, 8'd0);
`ifdef LC3_IMM_SAT_EN
    send_chk("t2_pos16", 16'h0010, 4'd5, 16'h1020, 16'h102F, 11'h00F, 1'b1, 8'd1);
    send_chk("t3_w9ovf", 16'h03FF, 4'd9, 16'h4800, 16'h48FF, 11'h0FF, 1'b1, 8'd2);
    send_chk("t3_w6neg", 16'hFF00, 4'd6, 16'hFFFF, 16'hFFE0, 11'h020, 1'b1, 8'd3);
`else
    send_chk("t2_pos16", 16'h0010, 4'd5, 16'h1020, 16'h1030, 11'h010, 1'b1, 8'd1);
    send_chk("t3_w9ovf", 16'h03FF, 4'd9, 16'h4800, 16'h49FF, 11'h1FF, 1'b1, 8'd2);
    send_chk("t3_w6neg", 16'hFF00, 4'd6, 16'hFFFF, 16'hFFC0, 11'h000, 1'b1, 8'd3);
`endif
    send_chk("t3_w11", 16'h03FF, 4'd11, 16'h4800, 16'h4BFF, 11'h3FF, 1'b0, 8'd3);
    send_chk("t4_w7", 16'h0001, 4'd7, 16'hABCD, 16'hABCD, 11'h000, 1'b1, 8'd4);

    // Backpressure: two words fill the FIFO, third waits until a slot frees.
    bus_if.out_ready = 1'b0;
    drive(16'h0001, 4'd5, 16'h0000);
    tick();
    drive(16'h0002, 4'd5, 16'h0000);
    tick();
    chk("t5.full_rdy", 32'(bus_if.in_ready), 32'd0);
    chk("t5.head_a", 32'(bus_if.out_field), 32'h001);
    drive(16'h0003, 4'd5, 16'h0000);
    tick();
    chk("t5.still_full", 32'(bus_if.in_ready), 32'd0);
    chk("t5.head_held", 32'(bus_if.out_field), 32'h001);
    bus_if.out_ready = 1'b1;
    tick();
    chk("t5.head_b", 32'(bus_if.out_field), 32'h002);
    chk("t5.rdy_again", 32'(bus_if.in_ready), 32'd1);
    tick();
    bus_if.in_valid = 1'b0;
    chk("t5.head_c", 32'(bus_if.out_field), 32'h003);
    chk("t5.c_vld", 32'(bus_if.out_valid), 32'd1);
    tick();
    chk("t5.empty", 32'(bus_if.out_valid), 32'd0);

    // Reset with two overflowing words queued.
    bus_if.out_ready = 1'b0;
    drive(16'h7FFF, 4'd5, 16'h0000);
    tick();
    tick();
    bus_if.in_valid = 1'b0;
    chk("t6.queued_err", 32'(err_count), 32'd6);
    chk("t6.queued_vld", 32'(bus_if.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_vld", 32'(bus_if.out_valid), 32'd0);
    chk("t6.rst_err", 32'(err_count), 32'd0);
    chk("t6.rst_instr", 32'(bus_if.out_instr), 32'd0);
    tick();
    rst = 1'b0;
    chk("t6.rel_rdy", 32'(bus_if.in_ready), 32'd1);
    tick();
    chk("t6.rel_vld", 32'(bus_if.out_valid), 32'd0);

    bus_if.out_ready = 1'b1;
    drive(16'h7FFF, 4'd5, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("t6.err100", 32'(err_count), 32'd100);
    end
    bus_if.in_valid = 1'b0;
    tick();
    chk("t6.err_sat", 32'(err_count), 32'd255);
    tick();
    chk("t6.err_hold", 32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
